// File: rtl/b3_digit_monitor_pkg.sv
// Shared constants for the base-3 digit monitor: state encodings, cause bit
// positions and the digit codes used by the monitored b3_counter.
package b3_digit_monitor_pkg;

    localparam logic [1:0] ST_ARM   = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam int unsigned CAUSE_ILLEGAL = 0;
    localparam int unsigned CAUSE_DIGIT   = 1;
    localparam int unsigned CAUSE_CARRY   = 2;
    localparam int unsigned CAUSE_W       = 3;

    localparam logic [1:0] D0   = 2'b00;
    localparam logic [1:0] D1   = 2'b01;
    localparam logic [1:0] D2   = 2'b10;
    localparam logic [1:0] DBAD = 2'b11;

endpackage

// File: rtl/b3_inc.sv
// Combinational base-3 increment of a single digit: 0->1, 1->2, 2->0.
module b3_inc
    import b3_digit_monitor_pkg::*;
(
    input  logic [1:0] d,
    output logic [1:0] d_inc
);

    // The illegal code maps to 0 so the result is always a legal digit.
    always_comb begin
        case (d)
            D0:      d_inc = D1;
            D1:      d_inc = D2;
            default: d_inc = D0;
        endcase
    end

endmodule

// File: rtl/b3_digit_monitor.sv
// Cycle-by-cycle checker for a b3_counter: predicts the digit, checks the
// carry, counts wraps (saturating) and latches the first fault with its cause.
module b3_digit_monitor
    import b3_digit_monitor_pkg::*;
#(
    parameter int unsigned WRAP_W      = 8,
    parameter bit          CHECK_CARRY = 1'b1
) (
    input  logic                clock,
    input  logic                reset_,
    input  logic                ei,
    input  logic                eu,
    input  logic [1:0]          q1_q0,
    input  logic                clear,
    output logic                armed,
    output logic                fault,
    output logic [CAUSE_W-1:0]  cause,
    output logic [WRAP_W-1:0]   wraps
);

    logic [1:0]         state_q, state_d;
    logic [1:0]         exp_q, exp_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [WRAP_W-1:0]  wraps_q, wraps_d;

    logic [1:0] q_inc;
    logic [1:0] exp_inc;
    logic       e0, e1, e2;

    b3_inc u_inc_q (
        .d     (q1_q0),
        .d_inc (q_inc)
    );

    b3_inc u_inc_exp (
        .d     (exp_q),
        .d_inc (exp_inc)
    );

    always_comb begin
        e0 = (q1_q0 == DBAD);
        e1 = !e0 && (q1_q0 != exp_q);
        e2 = CHECK_CARRY && (eu != (ei && (q1_q0 == D2)));
    end

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        cause_d = cause_q;
        wraps_d = wraps_q;

        // Wraps are counted in ARM and TRACK, including the edge entering FAULT.
        if ((state_q != ST_FAULT) && ei && eu && (wraps_q != '1)) begin
            wraps_d = wraps_q + WRAP_W'(1);
        end

        case (state_q)
            ST_ARM: begin
                if (e0) begin
                    state_d                = ST_FAULT;
                    cause_d                = '0;
                    cause_d[CAUSE_ILLEGAL] = 1'b1;
                end else begin
                    exp_d   = ei ? q_inc : q1_q0;
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (e0 || e1 || e2) begin
                    cause_d[CAUSE_ILLEGAL] = e0;
                    cause_d[CAUSE_DIGIT]   = e1;
                    cause_d[CAUSE_CARRY]   = e2;
                    state_d                = ST_FAULT;
                end else if (ei) begin
                    exp_d = exp_inc;
                end
            end
            default: begin
            end
        endcase

        if (clear) begin
            state_d = ST_ARM;
            exp_d   = D0;
            cause_d = '0;
            wraps_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q <= ST_ARM;
            exp_q   <= D0;
            cause_q <= '0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            cause_q <= cause_d;
            wraps_q <= wraps_d;
        end
    end

    assign armed = (state_q == ST_TRACK);
    assign fault = (state_q == ST_FAULT);
    assign cause = cause_q;
    assign wraps = wraps_q;

endmodule

// File: doc/b3_digit_monitor.md
Name: b3_digit_monitor

Overview:
- Cycle-by-cycle checker placed directly downstream of the b3_counter stage: it consumes that stage's ei, eu and q1_q0 and confirms the counter obeys the base-3 contract.
- Counts carries (wraps) and latches the first fault with its cause.
- Used in benches and as an on-chip sanity monitor feeding status registers.

Parameters:
- WRAP_W, 8, width of the saturating wrap counter
- CHECK_CARRY, 1, 1 = check eu against the expected carry; 0 = ignore eu for errors (wraps are still counted)

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_  in  1  reset, synchronous, active-low
- ei  in  1  enable presented to the monitored counter in this cycle
- eu  in  1  carry/enable-out produced by the monitored counter
- q1_q0  in  2  digit held by the monitored counter
- clear  in  1  synchronous clear of fault and statistics; returns to ARM
- armed  out  1  high while in TRACK
- fault  out  1  high while in FAULT (sticky)
- cause  out  3  first-fault cause, bit0 illegal code, bit1 wrong digit, bit2 wrong carry
- wraps  out  WRAP_W  number of carries seen since reset/clear, saturating at all-ones

Behaviour:
- Monitored contract:
  - Counter digit is 0 after reset.
  - On a clock edge with ei=1 the digit steps 0->1->2->0; with ei=0 it holds.
  - eu = ei & (q1_q0==2'b10), combinational in the same cycle.
  - Code 2'b11 is illegal.
- States: ARM, TRACK, FAULT.
- Reset (reset_=0 at an edge) or clear=1 at an edge:
  - Go to ARM; cause=0, wraps=0, fault=0, armed=0, exp=0.
  - reset_ has priority over clear; both override all other activity, including mid-operation and in FAULT.
- ARM:
  - At the next edge, if q1_q0 != 2'b11: exp <= ei ? inc3(q1_q0) : q1_q0, go to TRACK.
  - If q1_q0 is illegal, go to FAULT with cause=3'b001.
  - ARM performs no digit or carry check, which tolerates counter/monitor reset skew.
- TRACK, evaluated on the current inputs each cycle:
  - e0 = (q1_q0==2'b11).
  - e1 = !e0 & (q1_q0 != exp).
  - e2 = CHECK_CARRY & (eu != (ei & q1_q0==2'b10)).
  - If any error bit is set, at the edge: cause <= {e2,e1,e0} (several bits may be set together), go to FAULT, exp frozen.
  - Otherwise: exp <= ei ? inc3(exp) : exp; stay in TRACK.
  - inc3 maps 0->1, 1->2, 2->0.
- wraps:
  - Increments at an edge in ARM or TRACK when eu=1 and ei=1, including the edge that enters FAULT.
  - Saturates at 2^WRAP_W-1 with no rollover.
  - Frozen in FAULT.
- FAULT: all outputs hold until reset_ or clear; inputs are ignored.
- Output latency:
  - Outputs are registered, so a fault in cycle n shows on fault/cause in cycle n+1.
  - A carry in cycle n shows on wraps in cycle n+1.
- armed = (state==TRACK); fault = (state==FAULT); both registered/decoded from state, never combinational from inputs.
- Boundary cases:
  - ei=1 with q1_q0=2 and eu=0 gives cause bit2, unless CHECK_CARRY=0.
  - eu=1 with ei=0 gives cause bit2.
  - A single glitch to 2'b11 gives cause=3'b001, never bit1.

Decomposition:
- Shared include file holds:
  - state encodings (ARM=2'd0, TRACK=2'd1, FAULT=2'd2)
  - cause bit indices
  - digit constants (D0=2'b00, D1=2'b01, D2=2'b10, DBAD=2'b11)
- One natural sub-module, b3_inc, is a combinational inc3 on a 2-bit digit; it is reused by later base-3 blocks.
- Everything else stays in the top module.

Test Plan:
- Clean run: reset 10 ns, then pair with a real b3_counter, ei=1 for 30 cycles -> armed=1 from cycle 2, fault=0 throughout, wraps=10.
- Saturation: WRAP_W=2, ei=1 for 30 cycles -> wraps stops at 3, fault=0.
- Wrong digit: in TRACK with exp=1, force q1_q0=2'b10 -> next cycle fault=1, cause=3'b010, wraps unchanged.
- Carry faults:
  - q1_q0=2, ei=1, eu=0 -> fault=1, cause=3'b100.
  - Repeat with CHECK_CARRY=0 -> fault=0, wraps unchanged since eu=0.
- Illegal code: drive q1_q0=2'b11 during ARM, then again during TRACK -> cause=3'b001 in both cases.
- Clear and reset priority:
  - In FAULT, pulse clear one cycle -> next cycle fault=0, cause=0, wraps=0, state ARM; one cycle later armed=1.
  - Assert reset_=0 and clear=1 together mid-TRACK -> same result.
